// File: rtl/band_read_sequencer.sv
// LED band read sequencer: on col_start fetches one column of band memory in
// address order and streams it out through a small FWFT FIFO with credit-gated reads.
module band_read_sequencer #(
   parameter int ADDR_W        = 15,
   parameter int COL_W         = 9,
   parameter int BYTES_PER_COL = 64,
   parameter int RD_LAT        = 1,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              col_start,
   input  logic [COL_W-1:0]  col_idx,
   output logic              read,
   output logic [ADDR_W-1:0] r_addr,
   input  logic [7:0]        r_data,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              overrun
);
   localparam int BW = $clog2(BYTES_PER_COL);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

   if (COL_W + BW != ADDR_W) begin : g_bad_addr_w
      $error("band_read_sequencer: COL_W + log2(BYTES_PER_COL) must equal ADDR_W");
   end
   if ((RD_LAT < 1) || (RD_LAT > 3)) begin : g_bad_rd_lat
      $error("band_read_sequencer: RD_LAT must be 1..3");
   end
   if ((FIFO_DEPTH < RD_LAT + 1) || ((1 << PW) != FIFO_DEPTH)) begin : g_bad_depth
      $error("band_read_sequencer: FIFO_DEPTH must be a power of two >= RD_LAT+1");
   end

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
   logic [RD_LAT-1:0] infl_q, infl_d;
   logic [RD_LAT-1:0] infl_last_q, infl_last_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [8:0]        fifo_mem [FIFO_DEPTH];

   logic              emerge, emerge_last, fifo_empty;
   logic              pop, wr_en, rd_en, can_issue;
   logic [8:0]        head;
   logic [CW-1:0]     infl_cnt, occ;

   // FIFO head falls through from the returning read when the buffer is empty,
   // so a byte can leave in the same cycle it comes back from memory.
   always_comb begin
      emerge      = infl_q[RD_LAT-1];
      emerge_last = infl_last_q[RD_LAT-1];
      fifo_empty  = (cnt_q == '0);
      out_valid   = !fifo_empty || emerge;
      head        = fifo_empty ? {emerge_last, r_data} : fifo_mem[rd_ptr_q];
      out_data    = out_valid ? head[7:0] : 8'h00;
      out_last    = out_valid & head[8];
      pop         = out_valid & out_ready;
      wr_en       = emerge & !(fifo_empty & pop);
      rd_en       = pop & !fifo_empty;
      wr_ptr_d    = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
      cnt_d       = cnt_q + CW'(wr_en) - CW'(rd_en);
   end

   // Credits: everything buffered or still in flight, less this cycle's pop,
   // must leave room for one more byte before a read may issue.
   always_comb begin
      infl_cnt = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         infl_cnt = infl_cnt + CW'(infl_q[i]);
      end
      occ       = cnt_q + infl_cnt - CW'(pop);
      can_issue = (occ < CW'(FIFO_DEPTH));
   end

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      byte_cnt_d = byte_cnt_q;
      read       = 1'b0;
      done       = 1'b0;
      overrun    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (col_start) begin
               col_d      = col_idx;
               byte_cnt_d = '0;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            overrun = col_start;
            if (can_issue) begin
               read       = 1'b1;
               byte_cnt_d = byte_cnt_q + BW'(1);
               if (byte_cnt_q == '1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            overrun = col_start;
            if (pop && out_last) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      infl_d      = (infl_q << 1) | RD_LAT'(read);
      infl_last_d = (infl_last_q << 1) | RD_LAT'(read && (byte_cnt_q == '1));
   end

   assign r_addr = {col_q, byte_cnt_q};
   assign busy   = (state_q != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         byte_cnt_q  <= '0;
         infl_q      <= '0;
         infl_last_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         byte_cnt_q  <= byte_cnt_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_ptr_q] <= {emerge_last, r_data};
   end

endmodule

// File: tb/tb_band_read_sequencer.sv
// Bench for band_read_sequencer: two instances (RD_LAT 1 and 3) share stimulus and
// are checked against a column-level model plus a cycle table for the RD_LAT=1 timing.
module tb_band_read_sequencer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        col_start = 1'b0;
   logic [8:0]  col_idx = '0;
   logic        out_ready = 1'b0;
   logic [1:0]  rd_o, vld_o, last_o, busy_o, done_o, ovr_o;
   logic [14:0] addr_o [2];
   logic [7:0]  rdata_i [2];
   logic [7:0]  data_o [2];
   logic [7:0]  mem [32768];

   int total = 0;
   int bad = 0;

   bit         mbusy [2];
   logic [8:0] mcol [2];
   int         issued [2];
   int         acc [2];
   bit         pstall [2];
   logic [7:0] pdata [2];
   int         ovr_cnt [2];

   typedef struct {
      int cs; int idx; int rdy;
      int rd; int addr; int vld; int data; int last; int busy; int done; int ovr;
   } vec_t;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [7:0] pipe [LAT];
      band_read_sequencer #(.RD_LAT(LAT)) u_dut (
         .clk(clk), .rst(rst), .col_start(col_start), .col_idx(col_idx),
         .read(rd_o[g]), .r_addr(addr_o[g]), .r_data(rdata_i[g]),
         .out_data(data_o[g]), .out_valid(vld_o[g]), .out_ready(out_ready),
         .out_last(last_o[g]), .busy(busy_o[g]), .done(done_o[g]), .overrun(ovr_o[g]));
      // registered memory; junk returns whenever no read was issued
      always @(posedge clk) begin
         pipe[0] <= rd_o[g] ? mem[addr_o[g]] : 8'($urandom);
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign rdata_i[g] = pipe[LAT-1];
   end

   task automatic chkeq(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Column-level model: bytes of the accepted column in order, one credit window of DEPTH.
   task automatic mon();
      for (int i = 0; i < 2; i++) begin
         bit xfer, exp_done, was_busy;
         if (rst) begin
            mbusy[i]  = 1'b0;
            pstall[i] = 1'b0;
         end else begin
            was_busy = mbusy[i];
            chkeq($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(was_busy));
            chkeq($sformatf("overrun%0d", i), 32'(ovr_o[i]), 32'(col_start & was_busy));
            ovr_cnt[i] += int'(ovr_o[i]);
            if (!was_busy) chkeq($sformatf("idle_quiet%0d", i), 32'({rd_o[i], vld_o[i]}), 0);
            if (pstall[i]) begin
               chkeq($sformatf("stall_valid%0d", i), 32'(vld_o[i]), 1);
               chkeq($sformatf("stall_data%0d", i), 32'(data_o[i]), 32'(pdata[i]));
            end
            xfer = vld_o[i] & out_ready;
            exp_done = 1'b0;
            if (xfer) begin
               chkeq($sformatf("byte_pending%0d", i), 32'(acc[i] < issued[i]), 1);
               chkeq($sformatf("out_data%0d_b%0d", i, acc[i]), 32'(data_o[i]),
                     32'(mem[{mcol[i], 6'(acc[i])}]));
               chkeq($sformatf("out_last%0d_b%0d", i, acc[i]), 32'(last_o[i]), 32'(acc[i] == 63));
               exp_done = (acc[i] == 63);
               acc[i]++;
            end
            if (rd_o[i]) begin
               chkeq($sformatf("read_in_col%0d", i), 32'(issued[i] < 64), 1);
               chkeq($sformatf("r_addr%0d", i), 32'(addr_o[i]), 32'({mcol[i], 6'(issued[i])}));
               issued[i]++;
            end
            chkeq($sformatf("done%0d", i), 32'(done_o[i]), 32'(exp_done));
            chkeq($sformatf("outstanding%0d", i), 32'((issued[i] - acc[i]) <= DEPTH), 1);
            pstall[i] = vld_o[i] & ~out_ready;
            pdata[i]  = data_o[i];
            if (exp_done) mbusy[i] = 1'b0;
            if (col_start && !was_busy) begin
               mbusy[i]  = 1'b1;
               mcol[i]   = col_idx;
               issued[i] = 0;
               acc[i]    = 0;
            end
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      for (int i = 0; i < 2; i++) begin
         chkeq($sformatf("rst_read%0d", i), 32'(rd_o[i]), 0);
         chkeq($sformatf("rst_raddr%0d", i), 32'(addr_o[i]), 0);
         chkeq($sformatf("rst_valid%0d", i), 32'(vld_o[i]), 0);
         chkeq($sformatf("rst_data%0d", i), 32'(data_o[i]), 0);
         chkeq($sformatf("rst_last%0d", i), 32'(last_o[i]), 0);
         chkeq($sformatf("rst_busy%0d", i), 32'(busy_o[i]), 0);
         chkeq($sformatf("rst_done%0d", i), 32'(done_o[i]), 0);
         chkeq($sformatf("rst_ovr%0d", i), 32'(ovr_o[i]), 0);
      end
   endtask

   task automatic start_col(input logic [8:0] idx, input int pct);
      col_start = 1'b1;
      col_idx   = idx;
      out_ready = ($urandom_range(0, 99) < pct);
      cyc();
      col_start = 1'b0;
   endtask

   task automatic run_idle(input int pct, input int bound);
      int n = 0;
      while ((mbusy[0] || mbusy[1]) && n < bound) begin
         col_start = 1'b0;
         out_ready = ($urandom_range(0, 99) < pct);
         cyc();
         n++;
      end
      chkeq("column_timeout", 32'(mbusy[0] | mbusy[1]), 0);
      for (int i = 0; i < 2; i++) chkeq($sformatf("col_bytes%0d", i), 32'(acc[i]), 64);
   endtask

   initial begin
      vec_t tbl [11];
      int   o0, o1, pct;

      for (int a = 0; a < 32768; a++) mem[a] = 8'($urandom);
      for (int b = 0; b < 64; b++) begin
         mem[b] = 8'(b);
         mem[{9'd511, 6'(b)}] = 8'(255 - b);
      end

      //          cs idx rdy  rd addr vld data last busy done ovr
      tbl[0]  = '{1, 0, 1,   0, 0,   0,  0,   0,   0,   0,   0};
      tbl[1]  = '{0, 0, 1,   1, 0,   0,  0,   0,   1,   0,   0};
      tbl[2]  = '{0, 0, 1,   1, 1,   1,  0,   0,   1,   0,   0};
      tbl[3]  = '{0, 0, 1,   1, 2,   1,  1,   0,   1,   0,   0};
      tbl[4]  = '{1, 7, 1,   1, 3,   1,  2,   0,   1,   0,   1};
      tbl[5]  = '{0, 0, 0,   1, 4,   1,  3,   0,   1,   0,   0};
      tbl[6]  = '{0, 0, 0,   1, 5,   1,  3,   0,   1,   0,   0};
      tbl[7]  = '{0, 0, 0,   1, 6,   1,  3,   0,   1,   0,   0};
      tbl[8]  = '{0, 0, 0,   0, 0,   1,  3,   0,   1,   0,   0};
      tbl[9]  = '{0, 0, 1,   1, 7,   1,  3,   0,   1,   0,   0};
      tbl[10] = '{0, 0, 1,   1, 8,   1,  4,   0,   1,   0,   0};

      @(posedge clk);
      @(negedge clk);
      chk_reset_vals();
      mon();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // column 0 with exact RD_LAT=1 timing, an overrun and a credit stall
      for (int c = 0; c < 11; c++) begin
         col_start = tbl[c].cs[0];
         col_idx   = 9'(tbl[c].idx);
         out_ready = tbl[c].rdy[0];
         @(negedge clk);
         chkeq($sformatf("t%0d_read", c), 32'(rd_o[0]), tbl[c].rd);
         if (tbl[c].rd != 0) chkeq($sformatf("t%0d_addr", c), 32'(addr_o[0]), tbl[c].addr);
         chkeq($sformatf("t%0d_valid", c), 32'(vld_o[0]), tbl[c].vld);
         if (tbl[c].vld != 0) chkeq($sformatf("t%0d_data", c), 32'(data_o[0]), tbl[c].data);
         chkeq($sformatf("t%0d_last", c), 32'(last_o[0]), tbl[c].last);
         chkeq($sformatf("t%0d_busy", c), 32'(busy_o[0]), tbl[c].busy);
         chkeq($sformatf("t%0d_done", c), 32'(done_o[0]), tbl[c].done);
         chkeq($sformatf("t%0d_ovr", c), 32'(ovr_o[0]), tbl[c].ovr);
         mon();
         @(posedge clk);
         #1;
      end
      col_start = 1'b0;
      run_idle(100, 300);

      // top column, no wrap
      start_col(9'd511, 100);
      run_idle(100, 300);

      // 30% ready on column 5
      start_col(9'd5, 30);
      run_idle(30, 2000);

      // overrun mid-fetch and in the done cycle
      o0 = ovr_cnt[0];
      o1 = ovr_cnt[1];
      for (int c = 0; c < 70; c++) begin
         col_start = (c == 0) || (c == 11) || (c == 65);
         col_idx   = (c == 0) ? 9'd2 : 9'd9;
         out_ready = 1'b1;
         @(negedge clk);
         if (c == 65) begin
            chkeq("done_cycle_done", 32'(done_o[0]), 1);
            chkeq("done_cycle_ovr", 32'(ovr_o[0]), 1);
         end
         mon();
         @(posedge clk);
         #1;
      end
      col_start = 1'b0;
      run_idle(100, 100);
      chkeq("overrun_pulses0", ovr_cnt[0] - o0, 2);
      chkeq("overrun_pulses1", ovr_cnt[1] - o1, 2);

      // reset mid-column with the stream stalled
      for (int c = 0; c < 22; c++) begin
         col_start = (c == 0);
         col_idx   = 9'd4;
         out_ready = (c < 21);
         cyc();
      end
      rst = 1'b1;
      #1;
      chk_reset_vals();
      cyc();
      rst = 1'b0;
      start_col(9'd3, 50);
      run_idle(50, 1000);

      // random columns and ready duty
      for (int r = 0; r < 3; r++) begin
         pct = $urandom_range(20, 100);
         start_col(9'($urandom_range(0, 511)), pct);
         run_idle(pct, 3000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
